// File: rtl/uart_reg_bank.sv
`default_nettype none
// =============================================================================
// uart_reg_bank : UART ctrl/cfg registers, TX/RX byte FIFOs on a mem-style bus
// Rev 1.0
// =============================================================================
module uart_reg_bank #(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter logic [ADDR_W-1:0] REG_BASE = '0,
  parameter int              FIFO_DEPTH = 16,
  parameter logic [15:0]     DIV_RST    = 16'd868
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_W-1:0]     mem_waddr_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  input  logic [DATA_W/8-1:0]   mem_wstrb_i,
  output logic [1:0]            mem_wresp_o,
  input  logic                  mem_re_i,
  input  logic [ADDR_W-1:0]     mem_raddr_i,
  output logic [DATA_W-1:0]     mem_rdata_o,
  output logic [1:0]            mem_rresp_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic [15:0]           cfg_div_o,
  output logic                  cfg_par_en_o,
  output logic                  cfg_par_odd_o,
  output logic                  cfg_stop2_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] OFF_CFG    = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] OFF_TXCNT  = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] OFF_RXCNT  = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] OFF_TXDATA = ADDR_W'(32'h14);
  localparam logic [ADDR_W-1:0] OFF_RXDATA = ADDR_W'(32'h18);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic              tx_en_q, tx_en_d, rx_en_q, rx_en_d;
  logic [15:0]       div_q, div_d;
  logic              par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic              rx_ovf_q, rx_ovf_d;
  logic [PTR_W-1:0]  tx_rd_ptr_q, tx_rd_ptr_d, tx_wr_ptr_q, tx_wr_ptr_d;
  logic [PTR_W-1:0]  rx_rd_ptr_q, rx_rd_ptr_d, rx_wr_ptr_q, rx_wr_ptr_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]        tx_mem_q [FIFO_DEPTH];
  logic [7:0]        rx_mem_q [FIFO_DEPTH];

  logic [ADDR_W-1:0] woff, roff;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              wr_ctrl, wr_cfg, wr_status, wr_txdata, rd_en;
  logic              tx_push, tx_pop, tx_clr, rx_push, rx_pop, rx_clr, rx_ovf_set, rx_ovf_clr;

  assign woff = mem_waddr_i - REG_BASE;
  assign roff = mem_raddr_i - REG_BASE;

  assign tx_full  = (tx_cnt_q == CNT_W'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CNT_W'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  assign wr_ctrl   = mem_we_i && (woff == OFF_CTRL);
  assign wr_cfg    = mem_we_i && (woff == OFF_CFG);
  assign wr_status = mem_we_i && (woff == OFF_STATUS);
  assign wr_txdata = mem_we_i && (woff == OFF_TXDATA);
  assign rd_en     = mem_re_i && !mem_we_i;

  // Full/empty qualifiers all use pre-edge state, so a push to a full FIFO fails
  // even when a pop happens in the same cycle.
  assign tx_push    = wr_txdata && mem_wstrb_i[0] && !tx_full;
  assign tx_pop     = tx_valid_o && tx_ready_i;
  assign tx_clr     = wr_ctrl && mem_wstrb_i[0] && mem_wdata_i[2];
  assign rx_push    = rx_valid_i && rx_en_q && !rx_full;
  assign rx_ovf_set = rx_valid_i && rx_en_q && rx_full;
  assign rx_pop     = rd_en && (roff == OFF_RXDATA) && !rx_empty;
  assign rx_clr     = wr_ctrl && mem_wstrb_i[0] && mem_wdata_i[3];
  assign rx_ovf_clr = wr_status && mem_wstrb_i[0] && mem_wdata_i[4];

  assign tx_valid_o    = tx_en_q && !tx_empty;
  assign tx_data_o     = tx_empty ? 8'h00 : tx_mem_q[tx_rd_ptr_q];
  assign cfg_div_o     = div_q;
  assign cfg_par_en_o  = par_en_q;
  assign cfg_par_odd_o = par_odd_q;
  assign cfg_stop2_o   = stop2_q;

  always_comb begin
    mem_wresp_o = RESP_OKAY;
    if (mem_we_i) begin
      case (woff)
        OFF_CTRL, OFF_CFG, OFF_STATUS: mem_wresp_o = RESP_OKAY;
        OFF_TXDATA: mem_wresp_o = tx_push ? RESP_OKAY : RESP_SLVERR;
        default:    mem_wresp_o = RESP_SLVERR;
      endcase
    end
  end

  always_comb begin
    mem_rdata_o = '0;
    mem_rresp_o = RESP_OKAY;
    if (mem_re_i) begin
      if (mem_we_i) begin
        mem_rresp_o = RESP_SLVERR;
      end else begin
        case (roff)
          OFF_CTRL:   mem_rdata_o[1:0] = {rx_en_q, tx_en_q};
          OFF_CFG:    mem_rdata_o[18:0] = {stop2_q, par_odd_q, par_en_q, div_q};
          OFF_STATUS: mem_rdata_o[4:0] = {rx_ovf_q, rx_empty, rx_full, tx_empty, tx_full};
          OFF_TXCNT:  mem_rdata_o[CNT_W-1:0] = tx_cnt_q;
          OFF_RXCNT:  mem_rdata_o[CNT_W-1:0] = rx_cnt_q;
          OFF_RXDATA: begin
            if (rx_empty) mem_rresp_o = RESP_SLVERR;
            else          mem_rdata_o[7:0] = rx_mem_q[rx_rd_ptr_q];
          end
          default:    mem_rresp_o = RESP_SLVERR;
        endcase
      end
    end
  end

  always_comb begin
    tx_en_d     = tx_en_q;
    rx_en_d     = rx_en_q;
    div_d       = div_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    stop2_d     = stop2_q;
    rx_ovf_d    = rx_ovf_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_cnt_d    = rx_cnt_q;

    if (wr_ctrl && mem_wstrb_i[0]) begin
      tx_en_d = mem_wdata_i[0];
      rx_en_d = mem_wdata_i[1];
    end
    if (wr_cfg) begin
      if (mem_wstrb_i[0]) div_d[7:0]  = mem_wdata_i[7:0];
      if (mem_wstrb_i[1]) div_d[15:8] = mem_wdata_i[15:8];
      if (mem_wstrb_i[2]) begin
        par_en_d  = mem_wdata_i[16];
        par_odd_d = mem_wdata_i[17];
        stop2_d   = mem_wdata_i[18];
      end
    end

    // A new overflow beats a concurrent clear so no drop goes unreported.
    if (rx_ovf_clr) rx_ovf_d = 1'b0;
    if (rx_ovf_set) rx_ovf_d = 1'b1;

    if (tx_clr) begin
      tx_rd_ptr_d = '0;
      tx_wr_ptr_d = '0;
      tx_cnt_d    = '0;
    end else begin
      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(1);
      if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CNT_W'(1);
      if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT_W'(1);
    end

    if (rx_clr) begin
      rx_rd_ptr_d = '0;
      rx_wr_ptr_d = '0;
      rx_cnt_d    = '0;
    end else begin
      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PTR_W'(1);
      if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + CNT_W'(1);
      if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tx_en_q     <= 1'b0;
      rx_en_q     <= 1'b0;
      div_q       <= DIV_RST;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
      rx_ovf_q    <= 1'b0;
      tx_rd_ptr_q <= '0;
      tx_wr_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      tx_en_q     <= tx_en_d;
      rx_en_q     <= rx_en_d;
      div_q       <= div_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      stop2_q     <= stop2_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end

  // Storage needs no reset: empty FIFOs never expose their contents.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= mem_wdata_i[7:0];
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_data_i;
  end

  logic unused_bits;
  assign unused_bits = ^{mem_wdata_i[DATA_W-1:19], mem_wstrb_i[DATA_W/8-1:3]};

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bank.sv
`default_nettype none
// =============================================================================
// tb_uart_reg_bank : directed stimulus, queue-based reference model | Rev 1.0
// =============================================================================
module tb_uart_reg_bank;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  logic        clk = 1'b0;
  logic        arst_i = 1'b1;
  logic        mem_we_i = 1'b0, mem_re_i = 1'b0;
  logic [31:0] mem_waddr_i = '0, mem_wdata_i = '0, mem_raddr_i = '0;
  logic [3:0]  mem_wstrb_i = '0;
  logic [1:0]  mem_wresp_o, mem_rresp_o;
  logic [31:0] mem_rdata_o;
  logic [7:0]  tx_data_o, rx_data_i = '0;
  logic        tx_valid_o, tx_ready_i = 1'b0, rx_valid_i = 1'b0;
  logic [15:0] cfg_div_o;
  logic        cfg_par_en_o, cfg_par_odd_o, cfg_stop2_o;

  always #5 clk = ~clk;

  uart_reg_bank dut (
    .clk_i(clk), .arst_i(arst_i),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .mem_wstrb_i(mem_wstrb_i), .mem_wresp_o(mem_wresp_o),
    .mem_re_i(mem_re_i), .mem_raddr_i(mem_raddr_i), .mem_rdata_o(mem_rdata_o),
    .mem_rresp_o(mem_rresp_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .cfg_div_o(cfg_div_o), .cfg_par_en_o(cfg_par_en_o),
    .cfg_par_odd_o(cfg_par_odd_o), .cfg_stop2_o(cfg_stop2_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: register values plus FIFOs as queues.
  bit          m_tx_en = 0, m_rx_en = 0, m_ovf = 0;
  logic [31:0] m_cfg = 32'd868;
  logic [7:0]  m_txq[$];
  logic [7:0]  m_rxq[$];

  always @(posedge clk or posedge arst_i) begin
    bit txclr, rxclr, txpush, txpop, rxpush, rxpop, ovfset, w1c, n_tx_en, n_rx_en;
    logic [31:0] n_cfg;
    logic [7:0]  dummy;
    if (arst_i) begin
      m_tx_en = 0; m_rx_en = 0; m_ovf = 0; m_cfg = 32'd868;
      m_txq.delete(); m_rxq.delete();
    end else begin
      txclr = 0; rxclr = 0; txpush = 0; w1c = 0;
      n_tx_en = m_tx_en; n_rx_en = m_rx_en; n_cfg = m_cfg;
      if (mem_we_i) begin
        case (mem_waddr_i)
          32'h00: if (mem_wstrb_i[0]) begin
            n_tx_en = mem_wdata_i[0]; n_rx_en = mem_wdata_i[1];
            txclr = mem_wdata_i[2];   rxclr = mem_wdata_i[3];
          end
          32'h04: begin
            for (int b = 0; b < 3; b++)
              if (mem_wstrb_i[b]) n_cfg[8*b +: 8] = mem_wdata_i[8*b +: 8];
            n_cfg &= 32'h0007_FFFF;
          end
          32'h08: w1c = mem_wstrb_i[0] && mem_wdata_i[4];
          32'h14: txpush = mem_wstrb_i[0] && (m_txq.size() < 16);
          default: ;
        endcase
      end
      rxpop  = mem_re_i && !mem_we_i && (mem_raddr_i == 32'h18) && (m_rxq.size() > 0);
      txpop  = m_tx_en && (m_txq.size() > 0) && tx_ready_i;
      rxpush = rx_valid_i && m_rx_en && (m_rxq.size() < 16);
      ovfset = rx_valid_i && m_rx_en && (m_rxq.size() == 16);
      if (txclr) m_txq.delete();
      else begin
        if (txpop) dummy = m_txq.pop_front();
        if (txpush) m_txq.push_back(mem_wdata_i[7:0]);
      end
      if (rxclr) m_rxq.delete();
      else begin
        if (rxpop) dummy = m_rxq.pop_front();
        if (rxpush) m_rxq.push_back(rx_data_i);
      end
      if (w1c) m_ovf = 0;
      if (ovfset) m_ovf = 1;
      m_tx_en = n_tx_en; m_rx_en = n_rx_en; m_cfg = n_cfg;
    end
  end

  function automatic void exp_bus(output logic [1:0] ew, output logic [1:0] er,
                                  output logic [31:0] ed);
    ew = OK; er = OK; ed = '0;
    if (mem_we_i) begin
      case (mem_waddr_i)
        32'h00, 32'h04, 32'h08: ew = OK;
        32'h14: ew = (mem_wstrb_i[0] && m_txq.size() < 16) ? OK : SE;
        default: ew = SE;
      endcase
    end
    if (mem_re_i) begin
      if (mem_we_i) er = SE;
      else begin
        case (mem_raddr_i)
          32'h00: ed = {30'd0, m_rx_en, m_tx_en};
          32'h04: ed = m_cfg;
          32'h08: ed = {27'd0, m_ovf, m_rxq.size() == 0, m_rxq.size() == 16,
                        m_txq.size() == 0, m_txq.size() == 16};
          32'h0C: ed = 32'(m_txq.size());
          32'h10: ed = 32'(m_rxq.size());
          32'h18: if (m_rxq.size() > 0) ed = {24'd0, m_rxq[0]}; else er = SE;
          default: er = SE;
        endcase
      end
    end
  endfunction

  always @(negedge clk) begin
    logic [1:0]  ew, er;
    logic [31:0] ed;
    if (!arst_i) begin
      exp_bus(ew, er, ed);
      chk("m_tx_valid", 32'(tx_valid_o), 32'(m_tx_en && m_txq.size() > 0));
      chk("m_tx_data", 32'(tx_data_o), (m_txq.size() > 0) ? 32'(m_txq[0]) : 32'd0);
      chk("m_cfg_out", {13'd0, cfg_stop2_o, cfg_par_odd_o, cfg_par_en_o, cfg_div_o},
          m_cfg & 32'h0007_FFFF);
      chk("m_wresp", 32'(mem_wresp_o), 32'(ew));
      chk("m_rresp", 32'(mem_rresp_o), 32'(er));
      chk("m_rdata", mem_rdata_o, ed);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er, input string nm);
    mem_we_i = 1; mem_waddr_i = a; mem_wdata_i = d; mem_wstrb_i = s;
    @(negedge clk);
    chk(nm, 32'(mem_wresp_o), 32'(er));
    @(posedge clk); #1;
    mem_we_i = 0; mem_wstrb_i = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                    input string nm);
    mem_re_i = 1; mem_raddr_i = a;
    @(negedge clk);
    chk(nm, mem_rdata_o, ed);
    chk({nm, "_resp"}, 32'(mem_rresp_o), 32'(er));
    @(posedge clk); #1;
    mem_re_i = 0;
  endtask

  initial begin
    step(2);
    arst_i = 0;
    step(1);

    // Reset values
    rd(32'h04, 32'h0000_0364, OK, "rst_cfg");
    rd(32'h08, 32'h0000_000A, OK, "rst_status");
    chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);

    // CFG byte strobes
    wr(32'h04, 32'h0005_1234, 4'b0011, OK, "cfg_wr_lo");
    rd(32'h04, 32'h0000_1234, OK, "cfg_rd_lo");
    wr(32'h04, 32'h0005_1234, 4'b0100, OK, "cfg_wr_hi");
    rd(32'h04, 32'h0005_1234, OK, "cfg_rd_hi");
    chk("cfg_pins", {13'd0, cfg_stop2_o, cfg_par_odd_o, cfg_par_en_o, cfg_div_o}, 32'h0005_1234);

    // TX fill with tx_en=0
    wr(32'h14, 32'h99, 4'b0010, SE, "tx_push_nostrb");
    for (int i = 0; i < 16; i++) wr(32'h14, 32'h41 + i, 4'b0001, OK, "tx_push");
    wr(32'h14, 32'h51, 4'b0001, SE, "tx_push_full");
    rd(32'h0C, 32'd16, OK, "tx_cnt_full");
    rd(32'h08, 32'h09, OK, "status_txfull");
    chk("tx_hold", 32'(tx_valid_o), 32'd0);

    // Drain
    tx_ready_i = 1;
    wr(32'h00, 32'h1, 4'b0001, OK, "ctrl_txen");
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("drain_data", 32'(tx_data_o), 32'h41 + i);
      chk("drain_valid", 32'(tx_valid_o), 32'd1);
      @(posedge clk); #1;
    end
    chk("drain_done", 32'(tx_valid_o), 32'd0);
    rd(32'h0C, 32'd0, OK, "tx_cnt_empty");
    tx_ready_i = 0;

    // RX fill with overflow
    wr(32'h00, 32'h3, 4'b0001, OK, "ctrl_rxen");
    for (int i = 0; i < 17; i++) begin
      rx_valid_i = 1; rx_data_i = 8'(i);
      step(1);
    end
    rx_valid_i = 0;
    rd(32'h08, 32'h16, OK, "status_rxovf");
    rd(32'h10, 32'd16, OK, "rx_cnt_full");
    for (int i = 0; i < 16; i++) rd(32'h18, 32'(i), OK, "rx_pop");
    rd(32'h18, 32'd0, SE, "rx_pop_empty");
    rd(32'h08, 32'h1A, OK, "status_rxempty");
    wr(32'h08, 32'h10, 4'b0001, OK, "ovf_w1c");
    rd(32'h08, 32'h0A, OK, "status_ovfclr");

    // RX push + pop in one cycle
    for (int i = 0; i < 3; i++) begin
      rx_valid_i = 1; rx_data_i = 8'hA0 + 8'(i);
      step(1);
    end
    rx_data_i = 8'hA3;
    rd(32'h18, 32'hA0, OK, "rx_pushpop");
    rx_valid_i = 0;
    rd(32'h10, 32'd3, OK, "rx_cnt_same");

    // tx_clr during an active handshake
    wr(32'h14, 32'h61, 4'b0001, OK, "tx_push2");
    wr(32'h14, 32'h62, 4'b0001, OK, "tx_push2");
    tx_ready_i = 1;
    wr(32'h00, 32'h7, 4'b0001, OK, "ctrl_txclr");
    chk("txclr_valid", 32'(tx_valid_o), 32'd0);
    tx_ready_i = 0;
    rd(32'h0C, 32'd0, OK, "txclr_cnt");
    rd(32'h00, 32'h3, OK, "ctrl_rd");

    // Illegal accesses
    wr(32'h1C, 32'hFF, 4'hF, SE, "wr_1c");
    rd(32'h1C, 32'd0, SE, "rd_1c");
    rd(32'h02, 32'd0, SE, "rd_misalign");
    wr(32'h02, 32'hFF, 4'hF, SE, "wr_misalign");
    wr(32'h0C, 32'h1, 4'h1, SE, "wr_txcnt");
    wr(32'h18, 32'h1, 4'h1, SE, "wr_rxdata");
    rd(32'h14, 32'd0, SE, "rd_txdata");
    rd(32'h00, 32'h3, OK, "ctrl_unchanged");
    rd(32'h10, 32'd3, OK, "rx_cnt_unchanged");

    // Async reset in the middle of a burst
    wr(32'h04, 32'h0007_0001, 4'hF, OK, "cfg_wr_all");
    wr(32'h14, 32'h71, 4'b0001, OK, "tx_push3");
    wr(32'h14, 32'h72, 4'b0001, OK, "tx_push3");
    mem_we_i = 1; mem_waddr_i = 32'h14; mem_wdata_i = 32'h77; mem_wstrb_i = 4'b0001;
    #2 arst_i = 1;
    #1;
    chk("arst_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("arst_tx_data", 32'(tx_data_o), 32'd0);
    chk("arst_div", 32'(cfg_div_o), 32'd868);
    chk("arst_flags", {29'd0, cfg_stop2_o, cfg_par_odd_o, cfg_par_en_o}, 32'd0);
    mem_we_i = 0; mem_wstrb_i = '0;
    step(1);
    arst_i = 0;
    step(1);
    rd(32'h04, 32'h0000_0364, OK, "post_rst_cfg");
    rd(32'h08, 32'h0A, OK, "post_rst_status");
    rd(32'h0C, 32'd0, OK, "post_rst_txcnt");
    rd(32'h10, 32'd0, OK, "post_rst_rxcnt");
    rd(32'h00, 32'd0, OK, "post_rst_ctrl");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_reg_bank.md
Name: uart_reg_bank

Overview:
- Register bank consuming the simple memory-style request interface produced by the APB slave adapter: write strobe, address, data and byte strobes in; read data and 2-bit responses out.
- Holds UART control/config registers and two byte FIFOs (TX, RX).
- Feeds the UART TX serializer via a valid/ready byte stream.
- Accepts received bytes from the UART RX deserializer.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, data width; only 32 is supported.
- REG_BASE, 0, byte address of offset 0x00; offset = address - REG_BASE.
- FIFO_DEPTH, 16, entries per FIFO; must be a power of 2, at least 2.
- DIV_RST, 16'd868, reset value of CFG.div.

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- mem_we_i  in  1  write request, one access per high cycle
- mem_waddr_i  in  ADDR_W  write byte address
- mem_wdata_i  in  DATA_W  write data
- mem_wstrb_i  in  DATA_W/8  byte enables
- mem_wresp_o  out  2  write response: 00 OKAY, 10 SLVERR; combinational
- mem_re_i  in  1  read request, one access per high cycle
- mem_raddr_i  in  ADDR_W  read byte address
- mem_rdata_o  out  DATA_W  read data; combinational
- mem_rresp_o  out  2  read response: 00 OKAY, 10 SLVERR; combinational
- tx_data_o  out  8  TX FIFO head
- tx_valid_o  out  1  tx_en AND TX FIFO not empty
- tx_ready_i  in  1  serializer accepts byte
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  received byte strobe, one cycle
- cfg_div_o  out  16  baud divisor
- cfg_par_en_o  out  1  parity enable
- cfg_par_odd_o  out  1  odd parity
- cfg_stop2_o  out  1  two stop bits

Behaviour:
- Register map, word-aligned offsets; any other offset or addr[1:0]!=0 gives SLVERR with no side effect:
  - 0x00 CTRL RW: [0] tx_en, [1] rx_en, [2] tx_clr, [3] rx_clr. Clear bits are write-only pulses and read as 0.
  - 0x04 CFG RW: [15:0] div, [16] par_en, [17] par_odd, [18] stop2.
  - 0x08 STATUS: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] rx_ovf (sticky). Writes are OKAY; wdata[4]=1 with wstrb[0]=1 clears rx_ovf; other bits ignored.
  - 0x0C TX_CNT RO; 0x10 RX_CNT RO. Width clog2(FIFO_DEPTH)+1, zero-extended. Write gives SLVERR.
  - 0x14 TX_DATA WO: write with wstrb[0]=1 pushes wdata[7:0]. Full, or wstrb[0]=0, gives SLVERR and no push. Read gives SLVERR with rdata 0.
  - 0x18 RX_DATA RO: read returns the head in [7:0] (upper bits 0) and pops on the clock edge. Empty gives SLVERR with rdata 0 and no pop. Write gives SLVERR.
- RW registers honour wstrb per byte. Unused bits read 0.
- Responses and rdata are combinational from the current address and state. All state updates occur at the clock edge ending the access cycle.
- mem_we_i and mem_re_i are never high together; if they are, the write is served and the read returns SLVERR.
- Unselected response outputs are 00; mem_rdata_o is 0 when mem_re_i is low.
- TX drain: pop when tx_valid_o & tx_ready_i. Clearing tx_en holds the FIFO contents.
- Push and pop in the same cycle: both happen and the count is unchanged. Full/empty checks use the pre-edge state (push to a full FIFO fails even if a pop happens that cycle).
- RX fill: when rx_valid_i & rx_en, push rx_data_i. If the FIFO is full, drop the byte and set rx_ovf. If rx_en=0, ignore rx_valid_i.
- rx_ovf set and W1C in the same cycle: set wins.
- A tx_clr/rx_clr write empties that FIFO at the edge and overrides a concurrent push/pop to the same FIFO. The other CTRL bits written in the same access take effect normally.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Reset values: CTRL 0, CFG div=DIV_RST with other fields 0, rx_ovf 0, both FIFOs empty.
  - Outputs in reset: tx_valid_o 0, tx_data_o 0, cfg_div_o DIV_RST, other cfg outputs 0.
  - Reset mid-operation discards FIFO contents immediately (asynchronously).

Test Plan:
- Reset → read 0x04 returns 0x0000_0364 OKAY; 0x08 returns 0x0A; tx_valid_o 0.
- Write 0x04 data 0x0005_1234 strb 0b0011 → read 0x04 gives 0x0000_1234; strb 0b0100 then sets [16] and [18] → 0x0005_1234.
- tx_en=0: push 0x41, 0x42, ..., 16 bytes, all OKAY; 17th push SLVERR; TX_CNT=16; set tx_en with tx_ready_i=1 → tx_data_o sequence 0x41..0x50 on consecutive cycles, TX_CNT ends 0.
- rx_en=1: drive 17 rx bytes 0x00..0x10 → STATUS[4]=1, RX_CNT=16; reads of 0x18 return 0x00..0x0F OKAY; the next read is SLVERR with rdata 0; write 0x10 to 0x08 clears rx_ovf.
- RX push and RX_DATA read in the same cycle with 3 entries → read gets the old head, RX_CNT stays 3; tx_clr during tx handshake → TX_CNT 0, tx_valid_o 0 next cycle.
- Access 0x1C, 0x02, write 0x0C, read 0x14 → all SLVERR, no state change; assert arst_i mid-burst → FIFOs empty, cfg reset values.
